// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants and default width for the ALU
package alu_pkg;
   localparam int DATA_WIDTH = 8;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational result, carry and signed-overflow for all eight opcodes
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic           sa;
   logic           sb;
   assign sum = {1'b0, a} + {1'b0, b};
   // Extra MSB of the widened difference is the unsigned borrow.
   assign dif = {1'b0, a} - {1'b0, b};
   assign sa  = a[WIDTH-1];
   assign sb  = b[WIDTH-1];
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         OP_ADD: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (sa == sb) && (sum[WIDTH-1] != sa);
         end
         OP_SUB: begin
            result   = dif[WIDTH-1:0];
            carry    = dif[WIDTH];
            overflow = (sa != sb) && (dif[WIDTH-1] != sa);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = a << 1;
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = a >> 1;
            carry  = a[0];
         end
      endcase
   end
endmodule

// File: rtl/alu_core.sv
// alu_core: combinational ALU with zero detect and an enabled status register stage
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             en,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic [WIDTH-1:0] result_q,
   output logic             zero_q,
   output logic             carry_q,
   output logic             overflow_q
);
   alu_datapath #(.WIDTH(WIDTH)) u_dp (
      .a        (a),
      .b        (b),
      .op       (op),
      .result   (result),
      .carry    (carry),
      .overflow (overflow)
   );
   assign zero = ~|result;
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q   <= '0;
         zero_q     <= 1'b1;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else if (en) begin
         result_q   <= result;
         zero_q     <= zero;
         carry_q    <= carry;
         overflow_q <= overflow;
      end
   end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: table-driven, hand-written and random checks of alu_core against a reference model
module tb_alu_core;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       en;
   logic [7:0] result;
   logic       zero;
   logic       carry;
   logic       overflow;
   logic [7:0] result_q;
   logic       zero_q;
   logic       carry_q;
   logic       overflow_q;
   int errors = 0;
   int checks = 0;
   alu_core #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .op         (op),
      .en         (en),
      .result     (result),
      .zero       (zero),
      .carry      (carry),
      .overflow   (overflow),
      .result_q   (result_q),
      .zero_q     (zero_q),
      .carry_q    (carry_q),
      .overflow_q (overflow_q)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic       z;
      logic       c;
      logic       v;
   } vec_t;
   vec_t vecs[16];
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Arithmetic on plain integers: signed overflow is "true sum leaves [-128,127]".
   task automatic model(input int o, input int x, input int y, output int r, output int c, output int v);
      int sx, sy, t;
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      c = 0;
      v = 0;
      case (o)
         0: begin t = x + y; r = t % 256; c = (t > 255); v = (sx + sy > 127) || (sx + sy < -128); end
         1: begin r = (x - y + 256) % 256; c = (x < y); v = (sx - sy > 127) || (sx - sy < -128); end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = 255 - x;
         6: begin r = (x * 2) % 256; c = (x >= 128); end
         default: begin r = x / 2; c = x % 2; end
      endcase
   endtask
   task automatic check_comb(input string tag, input int r, input int c, input int v);
      check({tag, " result"}, result, r);
      check({tag, " zero"}, zero, (r == 0));
      check({tag, " carry"}, carry, c);
      check({tag, " overflow"}, overflow, v);
   endtask
   task automatic check_q(input string tag, input int r, input int z, input int c, input int v);
      check({tag, " result_q"}, result_q, r);
      check({tag, " zero_q"}, zero_q, z);
      check({tag, " carry_q"}, carry_q, c);
      check({tag, " overflow_q"}, overflow_q, v);
   endtask
   initial begin
      int er, ec, ev, qr, qz, qc, qv;
      vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0};
      vecs[1]  = '{3'd0, 8'h10, 8'h20, 8'h30, 0, 0, 0};
      vecs[2]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1};
      vecs[3]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 0, 1, 0};
      vecs[4]  = '{3'd1, 8'h20, 8'h10, 8'h10, 0, 0, 0};
      vecs[5]  = '{3'd1, 8'h00, 8'h00, 8'h00, 1, 0, 0};
      vecs[6]  = '{3'd2, 8'hAA, 8'h55, 8'h00, 1, 0, 0};
      vecs[7]  = '{3'd3, 8'hAA, 8'h55, 8'hFF, 0, 0, 0};
      vecs[8]  = '{3'd4, 8'hFF, 8'hFF, 8'h00, 1, 0, 0};
      vecs[9]  = '{3'd5, 8'hAA, 8'h33, 8'h55, 0, 0, 0};
      vecs[10] = '{3'd5, 8'hFF, 8'h00, 8'h00, 1, 0, 0};
      vecs[11] = '{3'd6, 8'h80, 8'hC3, 8'h00, 1, 1, 0};
      vecs[12] = '{3'd6, 8'hFF, 8'h00, 8'hFE, 0, 1, 0};
      vecs[13] = '{3'd7, 8'hFF, 8'h5A, 8'h7F, 0, 1, 0};
      vecs[14] = '{3'd7, 8'h01, 8'h00, 8'h00, 1, 1, 0};
      vecs[15] = '{3'd1, 8'h80, 8'h01, 8'h7F, 0, 0, 1};
      rst = 1'b1;
      en  = 1'b0;
      a   = 8'h00;
      b   = 8'h00;
      op  = 3'd0;
      @(posedge clk);
      #1;
      check_q("reset", 0, 1, 0, 0);
      rst = 1'b0;
      foreach (vecs[i]) begin
         op = vecs[i].op;
         a  = vecs[i].a;
         b  = vecs[i].b;
         #1;
         check($sformatf("vec%0d result", i), result, vecs[i].r);
         check($sformatf("vec%0d zero", i), zero, vecs[i].z);
         check($sformatf("vec%0d carry", i), carry, vecs[i].c);
         check($sformatf("vec%0d overflow", i), overflow, vecs[i].v);
      end
      @(negedge clk);
      en = 1'b1; op = 3'd0; a = 8'h10; b = 8'h20;
      @(posedge clk);
      #1;
      check_q("load 10+20", 8'h30, 0, 0, 0);
      en = 1'b0; a = 8'hFF; b = 8'h01;
      @(posedge clk);
      #1;
      check_q("hold", 8'h30, 0, 0, 0);
      check_comb("hold comb", 8'h00, 1, 0);
      en = 1'b1;
      @(posedge clk);
      #1;
      check_q("load FF+01", 8'h00, 1, 1, 0);
      a = 8'h7F;
      @(posedge clk);
      #1;
      check_q("load 7F+01", 8'h80, 0, 0, 1);
      rst = 1'b1; a = 8'h7F; b = 8'h01;
      @(posedge clk);
      #1;
      check_q("rst over en", 0, 1, 0, 0);
      check_comb("comb in rst", 8'h80, 0, 1);
      rst = 1'b0;
      qr = 0; qz = 1; qc = 0; qv = 0;
      for (int i = 0; i < 100; i++) begin
         a  = 8'($urandom);
         b  = 8'($urandom);
         op = 3'($urandom);
         en = 1'($urandom);
         #1;
         model(op, a, b, er, ec, ev);
         check_comb($sformatf("rand%0d op%0d", i, op), er, ec, ev);
         if (en) begin
            qr = er; qz = (er == 0); qc = ec; qv = ev;
         end
         @(posedge clk);
         #1;
         check_q($sformatf("rand%0d", i), qr, qz, qc, qv);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_core.md
# alu_core

8-bit combinational arithmetic/logic unit with an optional registered status stage. It computes one of eight operations on operands `a`/`b`, selected by a 3-bit opcode. It drives the result and a zero flag combinationally, with no clock latency. Carry/overflow flags and a clocked copy of all outputs feed downstream pipeline or status logic.

## Interface
- `WIDTH`, default 8: operand and result width. The bench exercises only 8.
- `clk`  in  1: single clock. Rising-edge active.
- `rst`  in  1: reset, synchronous, active-high.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B. Ignored by the NOT, SHL and SHR operations.
- `op`  in  3: operation select.
- `en`  in  1: load enable for the registered stage.
- `result`  out  WIDTH: combinational operation result.
- `zero`  out  1: combinational; 1 iff `result == 0`.
- `carry`  out  1: combinational carry/borrow/shift-out flag.
- `overflow`  out  1: combinational signed-overflow flag.
- `result_q`, `zero_q`, `carry_q`, `overflow_q`  out  WIDTH/1/1/1: registered copies of the four combinational outputs.

## Operation
- Opcode map:
  - 000 ADD: `a+b`, modulo 2^WIDTH.
  - 001 SUB: `a-b`, modulo 2^WIDTH.
  - 010 AND: `a&b`.
  - 011 OR: `a|b`.
  - 100 XOR: `a^b`.
  - 101 NOT: `~a`.
  - 110 SHL: `a<<1`, LSB filled with 0.
  - 111 SHR: `a>>1`, logical, MSB filled with 0.
- Width rule: the result is truncated to WIDTH bits; no sign extension anywhere.
- `zero` = NOR of all `result` bits, for every opcode.
- `carry`:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: borrow (1 iff `a < b` unsigned).
  - SHL: `a[WIDTH-1]`.
  - SHR: `a[0]`.
  - Logic ops and NOT: 0.
- `overflow` (two's-complement):
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from `a`.
  - All other opcodes: 0.
- Outputs have no X propagation for fully known inputs. All 8 opcodes are defined, so there is no default/illegal case.
- Registered stage: on a rising `clk` edge:
  - if `rst`, then `result_q=0`, `zero_q=1`, `carry_q=0`, `overflow_q=0`;
  - else if `en`, all four `_q` outputs load their combinational counterparts;
  - else they hold.

## Timing
- `result`, `zero`, `carry`, `overflow` are purely combinational from `a`, `b`, `op`. They are valid within the same timestep, and `clk` and `rst` have no effect on them.
- `_q` outputs have 1-cycle latency: values present at edge N are visible after edge N.
- Reset is synchronous. Asserting `rst` mid-stream clears the `_q` outputs at the next edge only and never touches the combinational outputs.
- `rst` has priority over `en` when both are high.
- Reset values: `result_q=0`, `zero_q=1`, `carry_q=0`, `overflow_q=0`. Combinational outputs have no reset value; they track the inputs.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `OP_ADD`…`OP_SHR` (3-bit);
  - `WIDTH` default constant.
- Natural split:
  - one combinational sub-module `alu_datapath`, which produces `result`, `carry` and `overflow`;
  - a top that adds the zero-detect and the `_q` register stage.

## Test plan
- ADD (op=000):
  - a=FF, b=01 -> result=00, zero=1, carry=1;
  - a=10, b=20 -> result=30, zero=0;
  - a=7F, b=01 -> result=80, overflow=1.
- SUB (op=001):
  - a=00, b=01 -> result=FF, zero=0, carry=1;
  - a=20, b=10 -> result=10;
  - a=00, b=00 -> result=00, zero=1.
- Logic ops:
  - AND AA&55 -> 00, zero=1;
  - OR AA|55 -> FF;
  - XOR FF^FF -> 00, zero=1;
  - NOT a=AA -> 55;
  - NOT a=FF -> 00, zero=1.
- Shifts:
  - SHL a=80 -> 00, zero=1, carry=1;
  - SHL a=FF -> FE;
  - SHR a=FF -> 7F, carry=1;
  - SHR a=01 -> 00, zero=1.
- Register stage:
  - rst=1 for one edge -> result_q=00, zero_q=1;
  - then en=1, a=10, b=20, op=ADD -> result_q=30 after next edge;
  - en=0 with new inputs -> `_q` outputs hold.
- Random: 100 random a/b/op vectors, checked 1 ns after apply against a reference model of the opcode map. Require zero failures, then print a pass/fail summary.
